// File: rtl/rename_pkg.sv
// Shared constants, tag/pointer types and circular-pointer helpers for the
// rename free list.
package rename_pkg;

  localparam int PHYS_REGS    = 64;
  localparam int ARCH_REGS    = 16;
  localparam int PHYS_INDEX   = 6;
  localparam int FL_DEPTH     = PHYS_REGS - ARCH_REGS;
  localparam int FL_INDEX     = 6;
  localparam int RENAME_WIDTH = 4;

  typedef logic [PHYS_INDEX-1:0] phys_tag_t;

  // Circular-buffer pointer: index into storage plus a lap (wrap) bit.
  typedef struct packed {
    logic                wrap;
    logic [FL_INDEX-1:0] idx;
  } fl_ptr_t;

  localparam logic [FL_INDEX:0] FL_DEPTH_W = FL_DEPTH[FL_INDEX:0];

  // Advance a pointer by 0..4 modulo FL_DEPTH, toggling the wrap bit on rollover.
  // Also normalises the out-of-range reset value of tail (idx == FL_DEPTH).
  function automatic fl_ptr_t fl_ptr_add(input fl_ptr_t p, input logic [2:0] n);
    logic [FL_INDEX:0] sum;
    logic [FL_INDEX:0] wrapped;
    fl_ptr_t           r;
    sum     = {1'b0, p.idx} + {{(FL_INDEX-2){1'b0}}, n};
    wrapped = sum - FL_DEPTH_W;
    if (sum >= FL_DEPTH_W) begin
      r.idx  = wrapped[FL_INDEX-1:0];
      r.wrap = ~p.wrap;
    end else begin
      r.idx  = sum[FL_INDEX-1:0];
      r.wrap = p.wrap;
    end
    return r;
  endfunction

  function automatic logic [FL_INDEX-1:0] fl_idx_add(input fl_ptr_t p, input logic [2:0] n);
    fl_ptr_t r;
    r = fl_ptr_add(p, n);
    return r.idx;
  endfunction

  // Number of entries from head up to (not including) tail.
  function automatic logic [FL_INDEX:0] fl_distance(input fl_ptr_t tail, input fl_ptr_t head);
    logic [FL_INDEX:0] t;
    logic [FL_INDEX:0] h;
    t = {1'b0, tail.idx};
    h = {1'b0, head.idx};
    if (tail.wrap == head.wrap) return t - h;
    else                        return t + FL_DEPTH_W - h;
  endfunction

endpackage

// File: rtl/fl_ram_4r4w.sv
// Free-list storage: FL_DEPTH tags, four combinational read ports and four
// write ports. Reset loads entry k with tag ARCH_REGS+k.
module fl_ram_4r4w
  import rename_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [RENAME_WIDTH-1:0][FL_INDEX-1:0]  rd_addr_i,
  output phys_tag_t [RENAME_WIDTH-1:0]           rd_data_o,
  input  logic [RENAME_WIDTH-1:0]                wr_en_i,
  input  logic [RENAME_WIDTH-1:0][FL_INDEX-1:0]  wr_addr_i,
  input  phys_tag_t [RENAME_WIDTH-1:0]           wr_data_i
);

  phys_tag_t mem_q [FL_DEPTH];
  phys_tag_t mem_d [FL_DEPTH];

  always_comb begin
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      rd_data_o[k] = mem_q[rd_addr_i[k]];
    end
  end

  // Write addresses come from a compacted, contiguous range so they never collide.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      if (wr_en_i[k]) mem_d[wr_addr_i[k]] = wr_data_i[k];
    end
  end

  // NOTE: this array is reset on purpose -- the initial free tags are its contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < FL_DEPTH; k++) begin
        mem_q[k] <= PHYS_INDEX'(ARCH_REGS + k);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/rename_free_list.sv
// Physical-tag free list for a 4-wide rename stage with speculative/committed
// heads. Optional stall counter built when FL_PERF_CNT_EN is defined.
module rename_free_list
  import rename_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          reqCount_i,
  output logic                grant_o,
  output logic [PHYS_INDEX-1:0] freeTag0_o,
  output logic [PHYS_INDEX-1:0] freeTag1_o,
  output logic [PHYS_INDEX-1:0] freeTag2_o,
  output logic [PHYS_INDEX-1:0] freeTag3_o,
  input  logic                relValid0_i,
  input  logic                relValid1_i,
  input  logic                relValid2_i,
  input  logic                relValid3_i,
  input  logic [PHYS_INDEX-1:0] relTag0_i,
  input  logic [PHYS_INDEX-1:0] relTag1_i,
  input  logic [PHYS_INDEX-1:0] relTag2_i,
  input  logic [PHYS_INDEX-1:0] relTag3_i,
  input  logic                recover_i,
  output logic [FL_INDEX:0]   freeCount_o,
  output logic [31:0]         stallCycles_o
);

  fl_ptr_t spec_head_q, spec_head_d;
  fl_ptr_t commit_head_q, commit_head_d;
  fl_ptr_t tail_q, tail_d;

  logic [RENAME_WIDTH-1:0]               rel_valid;
  phys_tag_t [RENAME_WIDTH-1:0]          rel_tag;
  logic [2:0]                            rel_prefix [RENAME_WIDTH];
  logic [2:0]                            rel_cnt;
  logic [RENAME_WIDTH-1:0][FL_INDEX-1:0] rd_addr;
  phys_tag_t [RENAME_WIDTH-1:0]          rd_data;
  logic [RENAME_WIDTH-1:0][FL_INDEX-1:0] wr_addr;
  logic                                  pop;

  assign rel_valid = {relValid3_i, relValid2_i, relValid1_i, relValid0_i};
  assign rel_tag   = {relTag3_i, relTag2_i, relTag1_i, relTag0_i};

  // Compact valid release lanes: lane k lands at tail + popcount(lanes below k).
  always_comb begin
    rel_cnt = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      rel_prefix[k] = rel_cnt;
      wr_addr[k]    = fl_idx_add(tail_q, rel_cnt);
      rel_cnt       = rel_cnt + {2'b00, rel_valid[k]};
    end
  end

  always_comb begin
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      rd_addr[k] = fl_idx_add(spec_head_q, 3'(k));
    end
  end

  fl_ram_4r4w u_ram (
    .clk       (clk),
    .rst_n     (reset),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .wr_en_i   (rel_valid),
    .wr_addr_i (wr_addr),
    .wr_data_i (rel_tag)
  );

  assign freeTag0_o  = rd_data[0];
  assign freeTag1_o  = rd_data[1];
  assign freeTag2_o  = rd_data[2];
  assign freeTag3_o  = rd_data[3];
  assign freeCount_o = fl_distance(tail_q, spec_head_q);

  // Requests of 5..7 are illegal and never granted.
  always_comb begin
    grant_o = (reqCount_i <= 3'd4) && ({{(FL_INDEX-2){1'b0}}, reqCount_i} <= freeCount_o);
    pop     = grant_o && !recover_i;
  end

  always_comb begin
    spec_head_d   = spec_head_q;
    commit_head_d = fl_ptr_add(commit_head_q, rel_cnt);
    tail_d        = fl_ptr_add(tail_q, rel_cnt);
    if (recover_i)  spec_head_d = commit_head_d;
    else if (pop)   spec_head_d = fl_ptr_add(spec_head_q, reqCount_i);
  end

  // NOTE: state registers use non-blocking assignments only; next-state is computed above.
  always_ff @(posedge clk) begin
    if (!reset) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= '{wrap: 1'b0, idx: FL_DEPTH_W[FL_INDEX-1:0]};
    end else begin
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
    end
  end

`ifdef FL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((reqCount_i != 3'd0) && !grant_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stallCycles_o = stall_cnt_q;
`else
  assign stallCycles_o = '0;
`endif

endmodule

// File: tb/tb_rename_free_list.sv
// Directed self-checking bench for rename_free_list; expected values are
// hand-computed from the free-list behaviour.
module tb_rename_free_list;
  import rename_pkg::*;

`ifdef FL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  reqCount_i;
  logic        grant_o;
  logic [5:0]  freeTag0_o, freeTag1_o, freeTag2_o, freeTag3_o;
  logic        relValid0_i, relValid1_i, relValid2_i, relValid3_i;
  logic [5:0]  relTag0_i, relTag1_i, relTag2_i, relTag3_i;
  logic        recover_i;
  logic [6:0]  freeCount_o;
  logic [31:0] stallCycles_o;

  int n_checks = 0;
  int n_errors = 0;

  rename_free_list dut (
    .clk           (clk),
    .reset         (reset),
    .reqCount_i    (reqCount_i),
    .grant_o       (grant_o),
    .freeTag0_o    (freeTag0_o),
    .freeTag1_o    (freeTag1_o),
    .freeTag2_o    (freeTag2_o),
    .freeTag3_o    (freeTag3_o),
    .relValid0_i   (relValid0_i),
    .relValid1_i   (relValid1_i),
    .relValid2_i   (relValid2_i),
    .relValid3_i   (relValid3_i),
    .relTag0_i     (relTag0_i),
    .relTag1_i     (relTag1_i),
    .relTag2_i     (relTag2_i),
    .relTag3_i     (relTag3_i),
    .recover_i     (recover_i),
    .freeCount_o   (freeCount_o),
    .stallCycles_o (stallCycles_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rel(input logic [3:0] v, input logic [5:0] t0, input logic [5:0] t1,
                         input logic [5:0] t2, input logic [5:0] t3);
    {relValid3_i, relValid2_i, relValid1_i, relValid0_i} = v;
    relTag0_i = t0; relTag1_i = t1; relTag2_i = t2; relTag3_i = t3;
  endtask

  task automatic check_tags(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, "_tag0"}, 32'(freeTag0_o), 32'(e0));
    check({tag, "_tag1"}, 32'(freeTag1_o), 32'(e1));
    check({tag, "_tag2"}, 32'(freeTag2_o), 32'(e2));
    check({tag, "_tag3"}, 32'(freeTag3_o), 32'(e3));
  endtask

  initial begin
    reset      = 1'b0;
    reqCount_i = 3'd0;
    recover_i  = 1'b0;
    set_rel(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    tick();
    reset = 1'b1;
    #1;

    // Reset state
    check_tags("rst", 16, 17, 18, 19);
    check("rst_count", 32'(freeCount_o), 32'd48);
    check("rst_stall", stallCycles_o, 32'd0);
    check("rst_grant0", 32'(grant_o), 32'd1);

    // Drain the whole list four tags at a time
    reqCount_i = 3'd4;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("drain_grant", 32'(grant_o), 32'd1);
      check("drain_count", 32'(freeCount_o), 32'(48 - 4 * i));
      check_tags("drain", 16 + 4 * i, 17 + 4 * i, 18 + 4 * i, 19 + 4 * i);
      tick();
    end
    check("empty_grant", 32'(grant_o), 32'd0);
    check("empty_count", 32'(freeCount_o), 32'd0);
    tick();
    check("empty_stall1", stallCycles_o, PERF ? 32'd1 : 32'd0);
    check("empty_count2", 32'(freeCount_o), 32'd0);

    // Sparse release mask 1010 into the empty list
    reqCount_i = 3'd0;
    set_rel(4'b1010, 6'd40, 6'd5, 6'd41, 6'd9);
    #1;
    check("rel_not_visible", 32'(freeCount_o), 32'd0);
    tick();
    set_rel(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    #1;
    check("rel_count", 32'(freeCount_o), 32'd2);
    check("rel_tag0", 32'(freeTag0_o), 32'd5);
    check("rel_tag1", 32'(freeTag1_o), 32'd9);
    reqCount_i = 3'd3;
    #1;
    check("req3_grant", 32'(grant_o), 32'd0);
    reqCount_i = 3'd2;
    #1;
    check("req2_grant", 32'(grant_o), 32'd1);

    // Illegal request of 5: no grant, no state change
    reqCount_i = 3'd5;
    #1;
    check("req5_grant", 32'(grant_o), 32'd0);
    tick();
    check("req5_count", 32'(freeCount_o), 32'd2);
    check("req5_tag0", 32'(freeTag0_o), 32'd5);
    check("req5_stall", stallCycles_o, PERF ? 32'd2 : 32'd0);

    // Top up to four free entries
    reqCount_i = 3'd0;
    set_rel(4'b0011, 6'd20, 6'd21, 6'd0, 6'd0);
    tick();
    set_rel(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    #1;
    check("top_count", 32'(freeCount_o), 32'd4);
    check_tags("top", 5, 9, 20, 21);

    // Pop 4 and release 4 in the same cycle
    reqCount_i = 3'd4;
    set_rel(4'b1111, 6'd30, 6'd31, 6'd32, 6'd33);
    #1;
    check("pr_grant", 32'(grant_o), 32'd1);
    check_tags("pr_old", 5, 9, 20, 21);
    tick();
    reqCount_i = 3'd0;
    set_rel(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    #1;
    check("pr_count", 32'(freeCount_o), 32'd4);
    check_tags("pr_new", 30, 31, 32, 33);

    // Recovery: allocate 8, commit 2, recover with one more commit
    reset = 1'b0;
    tick();
    reset = 1'b1;
    reqCount_i = 3'd4;
    tick();
    tick();
    reqCount_i = 3'd0;
    set_rel(4'b0011, 6'd0, 6'd1, 6'd0, 6'd0);
    tick();
    set_rel(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    #1;
    check("alloc_count", 32'(freeCount_o), 32'd42);
    check("alloc_tag0", 32'(freeTag0_o), 32'd24);
    recover_i  = 1'b1;
    reqCount_i = 3'd4;
    set_rel(4'b0001, 6'd2, 6'd0, 6'd0, 6'd0);
    #1;
    check("recov_grant", 32'(grant_o), 32'd1);
    tick();
    recover_i  = 1'b0;
    reqCount_i = 3'd0;
    set_rel(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    #1;
    check("recov_tag0", 32'(freeTag0_o), 32'd19);
    check("recov_tag1", 32'(freeTag1_o), 32'd20);
    check("recov_count", 32'(freeCount_o), 32'd48);
    // Committed head must now sit at 3: allocate 4, then recover back
    reqCount_i = 3'd4;
    tick();
    reqCount_i = 3'd0;
    #1;
    check("realloc_tag0", 32'(freeTag0_o), 32'd23);
    recover_i = 1'b1;
    tick();
    recover_i = 1'b0;
    #1;
    check("recov2_tag0", 32'(freeTag0_o), 32'd19);
    check("recov2_count", 32'(freeCount_o), 32'd48);

    // Stall once, then reset mid-stream with recover and requests active
    reqCount_i = 3'd5;
    tick();
    check("pre_rst_stall", stallCycles_o, PERF ? 32'd1 : 32'd0);
    reqCount_i = 3'd4;
    recover_i  = 1'b1;
    set_rel(4'b0001, 6'd7, 6'd0, 6'd0, 6'd0);
    reset = 1'b0;
    tick();
    reset      = 1'b1;
    recover_i  = 1'b0;
    reqCount_i = 3'd0;
    set_rel(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    #1;
    check("midrst_tag0", 32'(freeTag0_o), 32'd16);
    check("midrst_tag3", 32'(freeTag3_o), 32'd19);
    check("midrst_count", 32'(freeCount_o), 32'd48);
    check("midrst_stall", stallCycles_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rename_free_list.md
# rename_free_list

Free list of physical register tags for the 4-wide rename stage. Each cycle it supplies up to four free tags as new destination mappings for the rename map table write ports, and reclaims up to four old tags released at commit. It keeps a speculative head for rename and a committed head for retirement, so a pipeline recovery returns every tag allocated since the last commit in one cycle.

## Interface
- PHYS_REGS, 64, total physical registers
- ARCH_REGS, 16, architectural registers; must equal the map table depth
- PHYS_INDEX, 6, tag width; must equal the map table data width
- FL_DEPTH, PHYS_REGS-ARCH_REGS, free-list storage entries
- FL_INDEX, 6, ceil(log2(FL_DEPTH))
---
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low
- reqCount_i  in  3  tags requested this cycle (0..4), always lanes 0..reqCount_i-1
- grant_o  out  1  request accepted this cycle
- freeTag0_o..freeTag3_o  out  PHYS_INDEX each  tags at specHead+0..3
- relValid0_i..relValid3_i  in  1 each  commit lane k releases a tag
- relTag0_i..relTag3_i  in  PHYS_INDEX each  released old tag
- recover_i  in  1  flush: roll the speculative head back to the committed head
- freeCount_o  out  FL_INDEX+1  free entries available to rename
- stallCycles_o  out  32  count of stalled request cycles (see Configuration)

## Operation
- Circular buffer with pointers specHead, commitHead and tail, each FL_INDEX+1 bits including a wrap bit. Pointer arithmetic is modulo FL_DEPTH, and the wrap bit toggles on rollover.
- freeCount = tail − specHead.
- The conservation invariant guarantees the buffer never overflows, so there is no full flag.
- Grant and pop:
  - grant_o = (reqCount_i ≤ 4) && (reqCount_i ≤ freeCount).
  - When grant_o is 1 and recover_i is 0, specHead advances by reqCount_i.
  - When grant_o is 0, nothing pops. Rename must hold the bundle and retry.
  - reqCount_i of 5..7 is illegal and forces grant_o=0.
  - reqCount_i=0 gives grant_o=1 with no pop.
- Release:
  - Valid lanes are compacted in lane order using a prefix count. Lane k's tag is written at tail+prefix(k).
  - tail and commitHead both advance by relCnt = popcount(relValid). Each committed destination retires its own allocation and frees its old tag.
  - An arbitrary valid mask is legal, for example 4'b1010.
- Recovery: when recover_i=1, specHead <= commitHead+relCnt, which includes same-cycle commits. The rename pop is ignored and grant_o is still driven. Release proceeds normally.
- Simultaneous pop and release: next freeCount = freeCount − pop + relCnt. Tags released in a cycle are not visible to rename in that cycle.
- Reset state:
  - Entry k holds ARCH_REGS+k.
  - specHead=commitHead=0, and tail=FL_DEPTH (wrap bit clear).
  - freeTag0..3_o = 16,17,18,19; freeCount_o=48; grant_o follows reqCount_i; stallCycles_o=0.
  - Reset dominates recover_i and all other inputs.

## Timing
- freeTag*_o, grant_o and freeCount_o are combinational from current state (plus reqCount_i for grant_o), with zero latency. Rename writes freeTag*_o into the map table in the same cycle.
- Pointer and storage updates take effect at the next posedge.
- A released tag becomes poppable the cycle after release.
- After recover_i, restored tags appear on freeTag*_o the next cycle.

## Configuration
- FL_PERF_CNT_EN defined: stallCycles_o is a saturating 32-bit counter, incremented every cycle with reqCount_i≠0 and grant_o=0. It clears on reset.
- FL_PERF_CNT_EN undefined: no counter logic is built, and stallCycles_o is tied to 0.

## Structure
- Shared package rename_pkg holds:
  - constants PHYS_REGS, ARCH_REGS, PHYS_INDEX, FL_DEPTH, FL_INDEX and RENAME_WIDTH=4;
  - typedef phys_tag_t.
- One sub-module, fl_ram_4r4w: a FL_DEPTH×PHYS_INDEX storage array with 4 combinational read ports and 4 write ports. Its reset initialises entry k to ARCH_REGS+k.
- Pointer, compaction and grant logic live in the top module.

## Test plan
- Reset, then reqCount=4 for 12 cycles:
  - tags 16..63 are handed out in order;
  - on cycle 13, grant_o=0 and freeCount_o=0;
  - with FL_PERF_CNT_EN, stallCycles_o increments.
- Empty list, release mask 4'b1010 with tags 5 and 9:
  - freeCount_o=2 the next cycle, freeTag0/1_o=5,9;
  - reqCount=3 then gives grant_o=0, and reqCount=2 gives grant_o=1.
- Pop 4 and release 4 in the same cycle at freeCount=4:
  - grant_o=1, the popped tags are the old ones, and freeCount stays 4;
  - pointers wrap correctly across FL_DEPTH.
- Allocate 8 (tags 16..23), commit 2 (releasing 0 and 1), then recover_i together with 1 more release (tag 2):
  - specHead = commitHead = 3;
  - the next freeTag0_o is 19.
- Drive reset low mid-stream with recover_i and requests active:
  - the next cycle shows the reset state: freeTag0_o=16 and freeCount_o=48.
- Drive reqCount=5: grant_o=0 and no state change.
